led_sequencer: RTL and testbench

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_sequencer.sv | 112 +++++++++++
 tb/tb_led_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// led_sequencer: steps an 8-bit LED pattern on rising edges of a selectable slow clock
module led_sequencer (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        C025Hz,
   input  logic        C05Hz,
   input  logic        C1Hz,
   input  logic        C2Hz,
   input  logic [1:0]  speed_sel,
   input  logic [1:0]  mode,
   input  logic        run,
   output logic [7:0]  leds,
   output logic        step_pulse,
   output logic [15:0] step_count,
   output logic [1:0]  state_o
);
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10} state_t;
   state_t      state_q, state_d;
   logic [1:0]  sel_q, mode_q;
   logic [3:0]  srcs;
   logic        src, src_q, hold_q, tick;
   logic        dir_q, dir_d, nxt_dir, pulse_q, pulse_d;
   logic [7:0]  leds_q, leds_d, nxt;
   logic [15:0] cnt_q, cnt_d;

   function automatic logic [7:0] seed(input logic [1:0] m);
      return m == 2'b01 ? 8'h80 : m == 2'b11 ? 8'h00 : 8'h01;
   endfunction

   assign srcs       = {C2Hz, C1Hz, C05Hz, C025Hz};
   assign src        = srcs[sel_q];
   // hold_q masks the edge after a speed change (and the first edge after reset) so src_q
   // always reflects a real sample of the currently selected source before a tick can fire
   assign tick       = src & ~src_q & ~hold_q & (speed_sel == sel_q);
   assign leds       = leds_q;
   assign step_pulse = pulse_q;
   assign step_count = cnt_q;
   assign state_o    = state_q;

   // next pattern for one step; dir 0 = left, 1 = right; illegal one-hot patterns reseed
   always_comb begin
      nxt     = ~leds_q;
      nxt_dir = dir_q;
      if (mode_q != 2'b11 && !$onehot(leds_q)) begin
         nxt     = seed(mode_q);
         nxt_dir = 1'b0;
      end else if (mode_q == 2'b00) begin
         nxt = {leds_q[6:0], leds_q[7]};
      end else if (mode_q == 2'b01) begin
         nxt = {leds_q[0], leds_q[7:1]};
      end else if (mode_q == 2'b10) begin
         nxt     = !dir_q ? (leds_q[7] ? 8'h40 : leds_q << 1) : (leds_q[0] ? 8'h02 : leds_q >> 1);
         nxt_dir = !dir_q ? leds_q[7] : !leds_q[0];
      end
   end

   // sequencer FSM: load on start, reload on mode change, step on tick while running
   always_comb begin
      state_d = state_q;
      leds_d  = leds_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      case (state_q)
         IDLE: if (run) begin
            state_d = RUN;
            leds_d  = seed(mode_q);
            dir_d   = 1'b0;
            cnt_d   = 16'h0000;
         end
         RUN: if (!run) begin
            state_d = PAUSE;
         end else if (mode != mode_q) begin
            leds_d = seed(mode);
            dir_d  = 1'b0;
            cnt_d  = 16'h0000;
         end else if (tick) begin
            leds_d  = nxt;
            dir_d   = nxt_dir;
            cnt_d   = cnt_q + 16'h0001;
            pulse_d = 1'b1;
         end
         PAUSE: if (run) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   // state registers with asynchronous reset
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         sel_q   <= 2'b00;
         mode_q  <= 2'b00;
         src_q   <= 1'b0;
         hold_q  <= 1'b1;
         leds_q  <= 8'h00;
         dir_q   <= 1'b0;
         cnt_q   <= 16'h0000;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= speed_sel;
         mode_q  <= mode;
         src_q   <= src;
         hold_q  <= speed_sel != sel_q;
         leds_q  <= leds_d;
         dir_q   <= dir_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed-vector bench for led_sequencer
module tb_led_sequencer;
   logic        clk = 1'b0, reset = 1'b1;
   logic        c025 = 1'b0, c05 = 1'b0, c1 = 1'b0, c2 = 1'b0;
   logic [1:0]  speed_sel = 2'b11, mode = 2'b00;
   logic        run = 1'b1;
   logic [7:0]  leds;
   logic        step_pulse, sp;
   logic [15:0] step_count;
   logic [1:0]  state_o;
   int          checks = 0, failures = 0;
   logic [7:0]  pp [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                            8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

   led_sequencer dut (
      .CLOCK_50(clk), .reset(reset), .C025Hz(c025), .C05Hz(c05), .C1Hz(c1), .C2Hz(c2),
      .speed_sel(speed_sel), .mode(mode), .run(run), .leds(leds),
      .step_pulse(step_pulse), .step_count(step_count), .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // one full low->high->low pulse on C2Hz; sp captures step_pulse in the cycle after the tick edge
   task automatic do_tick();
      c2 = 1'b1;
      @(negedge clk);
      sp = step_pulse;
      c2 = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      cyc(3);
      check("rst_leds", leds, 8'h00);
      check("rst_state", state_o, 2'b00);
      check("rst_cnt", step_count, 16'h0);
      check("rst_pulse", step_pulse, 1'b0);
      reset = 1'b0;
      cyc(1);
      check("load_state", state_o, 2'b01);
      check("load_leds", leds, 8'h01);
      cyc(7);
      do_tick();
      check("first_leds", leds, 8'h02);
      check("first_pulse", sp, 1'b1);
      check("first_cnt", step_count, 16'd1);
      check("pulse_one_cycle", step_pulse, 1'b0);
      repeat (6) do_tick();
      check("rol_80", leds, 8'h80);
      do_tick();
      check("rol_wrap", leds, 8'h01);
      check("rol_cnt", step_count, 16'd8);
      mode = 2'b01;
      cyc(1);
      check("ror_seed", leds, 8'h80);
      check("ror_cnt_clr", step_count, 16'd0);
      repeat (7) do_tick();
      check("ror_01", leds, 8'h01);
      do_tick();
      check("ror_wrap", leds, 8'h80);
      mode = 2'b10;
      c2 = 1'b1;
      cyc(1);
      check("mchg_seed", leds, 8'h01);
      check("mchg_cnt", step_count, 16'd0);
      check("mchg_pulse", step_pulse, 1'b0);
      c2 = 1'b0;
      cyc(1);
      for (int i = 0; i < 15; i++) begin
         do_tick();
         check($sformatf("pp_%0d", i), leds, pp[i]);
      end
      check("pp_cnt", step_count, 16'd15);
      speed_sel = 2'b10;
      c1 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         check($sformatf("sel_nopulse_%0d", i), step_pulse, 1'b0);
      end
      check("sel_noleds", leds, 8'h02);
      check("sel_nocnt", step_count, 16'd15);
      c1 = 1'b0;
      cyc(1);
      c1 = 1'b1;
      cyc(1);
      check("sel_step_leds", leds, 8'h04);
      check("sel_step_pulse", step_pulse, 1'b1);
      c1 = 1'b0;
      speed_sel = 2'b11;
      cyc(3);
      check("sel_once_cnt", step_count, 16'd16);
      mode = 2'b11;
      cyc(1);
      check("blink_seed", leds, 8'h00);
      do_tick();
      check("blink_ff", leds, 8'hFF);
      run = 1'b0;
      c2 = 1'b1;
      cyc(1);
      check("pause_state", state_o, 2'b10);
      check("pause_edge_leds", leds, 8'hFF);
      check("pause_edge_pulse", step_pulse, 1'b0);
      c2 = 1'b0;
      cyc(1);
      do_tick();
      check("pause_hold_leds", leds, 8'hFF);
      check("pause_hold_pulse", sp, 1'b0);
      check("pause_hold_cnt", step_count, 16'd1);
      run = 1'b1;
      cyc(1);
      check("resume_state", state_o, 2'b01);
      check("resume_leds", leds, 8'hFF);
      do_tick();
      check("resume_step", leds, 8'h00);
      check("resume_cnt", step_count, 16'd2);
      force dut.cnt_q = 16'hFFFE;
      @(posedge clk);
      #1 release dut.cnt_q;
      @(negedge clk);
      check("preload", step_count, 16'hFFFE);
      do_tick();
      check("cnt_ffff", step_count, 16'hFFFF);
      do_tick();
      check("cnt_wrap", step_count, 16'h0000);
      mode = 2'b00;
      cyc(1);
      force dut.leds_q = 8'h00;
      @(posedge clk);
      #1 release dut.leds_q;
      @(negedge clk);
      do_tick();
      check("illegal_reseed", leds, 8'h01);
      do_tick();
      check("after_reseed", leds, 8'h02);
      #2 reset = 1'b1;
      #1;
      check("async_leds", leds, 8'h00);
      check("async_state", state_o, 2'b00);
      cyc(1);
      do_tick();
      check("rst_tick_leds", leds, 8'h00);
      check("rst_tick_cnt", step_count, 16'h0);
      run = 1'b0;
      c2 = 1'b1;
      cyc(1);
      reset = 1'b0;
      cyc(2);
      check("wait_run", state_o, 2'b00);
      run = 1'b1;
      cyc(1);
      check("rerun_state", state_o, 2'b01);
      check("rerun_leds", leds, 8'h01);
      cyc(2);
      check("held_high_nostep", leds, 8'h01);
      c2 = 1'b0;
      cyc(1);
      do_tick();
      check("rerun_step", leds, 8'h02);
      check("rerun_cnt", step_count, 16'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
